// File: rtl/fifo_axis_reader.sv
// Drains a fixed-latency synchronous FIFO onto an AXI-Stream master port.
// Optional tlast generation when FIFO_AXIS_READER_TLAST_EN is defined.
module fifo_axis_reader #(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4,
  parameter int BURST_LEN  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  input  logic [DATA_W-1:0]          fifo_dout,
  output logic                       fifo_re,
  output logic [DATA_W-1:0]          m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
`ifdef FIFO_AXIS_READER_TLAST_EN
  output logic                       m_tlast,
`endif
  output logic [$clog2(BUF_DEPTH):0] occupancy
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0]     buf_q [BUF_DEPTH];
  logic [SW-1:0]         infl_cnt;
  logic [SW-1:0]         used;
  logic [SW-1:0]         limit;
  logic                  push;
  logic                  pop;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      infl_cnt = infl_cnt + SW'(pipe_q[i]);
  end

  assign push     = pipe_q[RD_LATENCY-1];
  assign m_tvalid = (count_q != '0);
  assign pop      = m_tvalid & m_tready;

  // A word leaving this cycle frees its slot for a new read.
  assign used    = SW'(count_q) + infl_cnt;
  assign limit   = SW'(BUF_DEPTH) + SW'(pop);
  assign fifo_re = !rst && !fifo_empty && (used < limit);

  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = fifo_re;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pipe_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pipe_q   <= pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      buf_q[wr_ptr_q] <= fifo_dout;
  end

  assign m_tdata   = m_tvalid ? buf_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

`ifdef FIFO_AXIS_READER_TLAST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  logic [BW-1:0] burst_q, burst_d;

  always_comb begin
    burst_d = burst_q;
    if (pop)
      burst_d = (burst_q == LAST) ? '0 : burst_q + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) burst_q <= '0;
    else     burst_q <= burst_d;
  end

  assign m_tlast = m_tvalid && (burst_q == LAST);
`endif

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader with a latency-2 FIFO model.
// Define FIFO_AXIS_READER_TLAST_EN to also check tlast (BURST_LEN=4).
module tb_fifo_axis_reader;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef FIFO_AXIS_READER_TLAST_EN
  localparam int BL = 4;
`else
  localparam int BL = 16;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_re;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [2:0]    occupancy;
`ifdef FIFO_AXIS_READER_TLAST_EN
  logic          m_tlast;
`endif

  always #5 clk = ~clk;

  fifo_axis_reader #(
    .DATA_W(DW), .RD_LATENCY(2), .BUF_DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .fifo_re(fifo_re),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
`ifdef FIFO_AXIS_READER_TLAST_EN
    .m_tlast(m_tlast),
`endif
    .occupancy(occupancy)
  );

  int n_chk = 0;
  int n_fail = 0;
  int re_cnt = 0;
  int xfer_cnt = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] load_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rd1 = '0;
  bit            rst_prev = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    load_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // Synchronous FIFO: data appears two edges after the read-enable edge.
  always @(posedge clk) begin
    if (rst && !rst_prev) fq.delete();
    rst_prev <= rst;
    if (fifo_re && fq.size() > 0) rd1 <= fq.pop_front();
    else                          rd1 <= $urandom();
    fifo_dout <= rd1;
    while (load_q.size() > 0) fq.push_back(load_q.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor / scoreboard
  bit            held_v = 1'b0;
  logic [DW-1:0] held_d = '0;
  int            bcnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
      bcnt = 0;
    end else begin
      chk(!(fifo_re && fifo_empty), "re_on_empty", 32'(fifo_re), 0);
      chk(occupancy <= DEPTH, "occ_bound", 32'(occupancy), DEPTH);
      chk(m_tvalid == (occupancy != 0), "valid_vs_occ",
          32'(m_tvalid), 32'(occupancy != 0));
`ifdef FIFO_AXIS_READER_TLAST_EN
      chk(m_tlast == (m_tvalid && bcnt == BL - 1), "tlast",
          32'(m_tlast), 32'(m_tvalid && bcnt == BL - 1));
`endif
      if (held_v)
        chk(m_tvalid && m_tdata == held_d, "hold_stable", m_tdata, held_d);
      if (fifo_re) re_cnt++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_word", m_tdata, 0);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          chk(m_tdata == e, "data", m_tdata, e);
        end
        bcnt = (bcnt + 1) % BL;
        xfer_cnt++;
      end
      held_v = m_tvalid && !m_tready;
      held_d = m_tdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] re_v, tv_v;
    int r0, x0, bub, stale;
    bit found;

    // Reset hold with a non-empty FIFO
    rst = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 load(32'hDEADBEEF);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(fifo_re == 1'b0, "rst_re", 32'(fifo_re), 0);
      chk(m_tvalid == 1'b0, "rst_valid", 32'(m_tvalid), 0);
      chk(occupancy == 0, "rst_occ", 32'(occupancy), 0);
    end

    // Single word latency
    @(posedge clk);
    #1 rst = 1'b0;
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      re_v[i] = fifo_re;
      tv_v[i] = m_tvalid;
    end
    chk(re_v == 8'b0000_0001, "single_re", 32'(re_v), 32'h01);
    chk(tv_v == 8'b0000_1000, "single_valid", 32'(tv_v), 32'h08);
    chk(xfer_cnt - x0 == 1, "single_xfers", xfer_cnt - x0, 1);

    // Streaming, no bubbles
    @(posedge clk);
    #1;
    for (int w = 0; w < 64; w++) load(32'(w));
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m_tvalid;
    end
    chk(found, "stream_start", 32'(found), 1);
    bub = 0;
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      if (!m_tvalid) bub++;
    end
    chk(bub == 0, "stream_bubbles", bub, 0);
    @(negedge clk);
    chk(m_tvalid == 1'b0, "stream_end", 32'(m_tvalid), 0);

    // Backpressure
    @(posedge clk);
    #1 m_tready = 1'b0;
    r0 = re_cnt;
    for (int w = 0; w < 20; w++) load(32'hA000_0000 + 32'(w));
    repeat (15) @(negedge clk);
    chk(re_cnt - r0 == DEPTH, "bp_re_pulses", re_cnt - r0, DEPTH);
    chk(occupancy == DEPTH, "bp_occ", 32'(occupancy), DEPTH);
    x0 = xfer_cnt;
    for (int i = 0; i < 200 && (xfer_cnt - x0) < 20; i++) begin
      @(posedge clk);
      #1 m_tready = ~m_tready;
    end
    chk(xfer_cnt - x0 == 20, "bp_xfers", xfer_cnt - x0, 20);
    chk(exp_q.size() == 0, "bp_drained", exp_q.size(), 0);

    // Reset mid-stream with reads in flight
    @(posedge clk);
    #1 m_tready = 1'b0;
    r0 = re_cnt;
    for (int w = 0; w < 20; w++) load(32'hB000_0000 + 32'(w));
    for (int i = 0; i < 20 && occupancy != 2; i++) @(negedge clk);
    chk(occupancy == 2, "mid_occ", 32'(occupancy), 2);
    chk(re_cnt - r0 == 4, "mid_inflight", re_cnt - r0, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk(m_tvalid == 1'b0, "mid_rst_valid", 32'(m_tvalid), 0);
    chk(occupancy == 0, "mid_rst_occ", 32'(occupancy), 0);
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_tvalid) stale++;
    end
    chk(stale == 0, "mid_no_stale", stale, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1 m_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        int n;
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) load($urandom());
      end
    end
    for (int i = 0; i < 300 && (exp_q.size() != 0 || m_tvalid); i++) begin
      @(posedge clk);
      #1 m_tready = 1'b1;
    end
    chk(exp_q.size() == 0, "rand_drained", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
